lsu: RTL and testbench

Load/store unit for the RV32I core: sits directly downstream of the ALU, taking its result as the effective address and rs2 as store data. Performs byte/halfword/word loads and stores against an internal data memory and a small memory-mapped I/O window (LEDs, 7-segment, switches). Returns load data, sign- or zero-extended, to writeback through a valid/ready request and a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_dmem.sv | 27 ++
 rtl/lsu.sv | 204 ++++++++++++++++++++
 tb/tb_lsu.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, address map, FSM states
// and the byte-lane merge helper used by both DMEM and the I/O registers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] DMEM_END  = 32'h0000_1FFF;
    localparam logic [31:0] LEDR_ADDR = 32'h0000_7000;
    localparam logic [31:0] LEDG_ADDR = 32'h0000_7010;
    localparam logic [31:0] HEX_ADDR  = 32'h0000_7020;
    localparam logic [31:0] SW_ADDR   = 32'h0000_7800;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_e;

    typedef enum logic [2:0] {
        RGN_DMEM,
        RGN_LEDR,
        RGN_LEDG,
        RGN_HEX,
        RGN_SW,
        RGN_NONE
    } lsu_region_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Data memory: synchronous-read single-port SRAM with per-byte write enables and no reset.
module dmem #(
    parameter int unsigned WORDS = 2048,
    parameter int unsigned AW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: decodes and validates a request at accept, then runs a fixed
// three-cycle IDLE/ACCESS/RESP sequence against DMEM or the memory-mapped I/O registers.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DMEM_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic [31:0] io_sw,
    output logic [31:0] io_ledr,
    output logic [31:0] io_ledg,
    output logic [31:0] io_hex
);

    localparam int unsigned AW = $clog2(DMEM_WORDS);

    lsu_state_e  state_q, state_d;
    lsu_region_e region, region_q;
    logic        req_err;
    logic        we_q, err_q;
    logic [2:0]  funct3_q;
    logic [AW+1:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] sw_meta_q, sw_sync_q;

    logic [3:0]  be;
    logic [31:0] lane;
    logic        commit, dmem_we;
    logic [31:0] dmem_rdata;
    logic [31:0] word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    always_comb begin
        region = RGN_NONE;
        if (req_addr[31:2] <= DMEM_END[31:2]) begin
            region = RGN_DMEM;
        end else if (req_addr[31:2] == LEDR_ADDR[31:2]) begin
            region = RGN_LEDR;
        end else if (req_addr[31:2] == LEDG_ADDR[31:2]) begin
            region = RGN_LEDG;
        end else if (req_addr[31:2] == HEX_ADDR[31:2]) begin
            region = RGN_HEX;
        end else if (req_addr[31:2] == SW_ADDR[31:2]) begin
            region = RGN_SW;
        end
    end

    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            F3_B, F3_BU: req_err = 1'b0;
            F3_H, F3_HU: req_err = req_addr[0];
            F3_W:        req_err = |req_addr[1:0];
            default:     req_err = 1'b1;
        endcase
        if (req_we && (req_funct3 == F3_BU || req_funct3 == F3_HU)) req_err = 1'b1;
        if (region == RGN_NONE) req_err = 1'b1;
        if (req_we && region == RGN_SW) req_err = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ACCESS;
            end
            ACCESS:  state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            region_q <= RGN_NONE;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                we_q     <= req_we;
                err_q    <= req_err;
                funct3_q <= req_funct3;
                addr_q   <= req_addr[AW+1:0];
                wdata_q  <= req_wdata;
                region_q <= region;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q <= 32'h0;
            sw_sync_q <= 32'h0;
        end else begin
            sw_meta_q <= io_sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        be   = 4'b1111;
        lane = wdata_q;
        case (funct3_q)
            F3_B: begin
                be   = 4'b0001 << addr_q[1:0];
                lane = {4{wdata_q[7:0]}};
            end
            F3_H: begin
                be   = addr_q[1] ? 4'b1100 : 4'b0011;
                lane = {2{wdata_q[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    assign commit  = (state_q == ACCESS) && we_q && !err_q;
    assign dmem_we = commit && (region_q == RGN_DMEM) && !rst;

    dmem #(
        .WORDS(DMEM_WORDS),
        .AW   (AW)
    ) u_dmem (
        .clk  (clk),
        .we   (dmem_we),
        .be   (be),
        .addr (addr_q[AW+1:2]),
        .wdata(lane),
        .rdata(dmem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_ledr <= 32'h0;
            io_ledg <= 32'h0;
            io_hex  <= 32'h0;
        end else if (commit) begin
            case (region_q)
                RGN_LEDR: io_ledr <= merge_bytes(io_ledr, lane, be);
                RGN_LEDG: io_ledg <= merge_bytes(io_ledg, lane, be);
                RGN_HEX:  io_hex  <= merge_bytes(io_hex, lane, be);
                default:  ;
            endcase
        end
    end

    always_comb begin
        case (region_q)
            RGN_DMEM: word = dmem_rdata;
            RGN_LEDR: word = io_ledr;
            RGN_LEDG: word = io_ledg;
            RGN_HEX:  word = io_hex;
            RGN_SW:   word = sw_sync_q;
            default:  word = 32'h0;
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_q[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        case (funct3_q)
            F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_val = {24'h0, byte_sel};
            F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_val = {16'h0, half_sel};
            default: load_val = word;
        endcase
    end

    assign rsp_rdata = (state_q == RESP && !we_q && !err_q) ? load_val : 32'h0;
    assign rsp_err   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu: a byte-level memory/register model predicts every
// response and the I/O register contents, checked cycle by cycle.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] io_sw, io_ledr, io_ledg, io_hex;

    lsu #(.DMEM_WORDS(2048)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .io_sw     (io_sw),
        .io_ledr   (io_ledr),
        .io_ledg   (io_ledg),
        .io_hex    (io_hex)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference state: byte-addressed DMEM and architectural register values.
    logic [7:0]  m_mem [0:8191];
    logic [31:0] m_ledr = 0, m_ledg = 0, m_hex = 0;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] ledr, ledg, hex;
    } exp_t;
    exp_t q[$];

    logic [31:0] cur_ledr = 0, cur_ledg = 0, cur_hex = 0;

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int size;
        bit sgn;
        int rid;
        int off;
        logic [31:0] base, w, v;
        size = 0;
        sgn  = 0;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: size = 0;
        endcase
        base = {a[31:2], 2'b00};
        off  = int'(a[1:0]);
        if (a < 32'h2000)              rid = 0;
        else if (base == 32'h7000)     rid = 1;
        else if (base == 32'h7010)     rid = 2;
        else if (base == 32'h7020)     rid = 3;
        else if (base == 32'h7800)     rid = 4;
        else                           rid = -1;
        er = (size == 0) || (rid < 0) || (we && (f3 == 3'd4 || f3 == 3'd5)) || (we && rid == 4);
        if (size != 0 && (off % size) != 0) er = 1'b1;
        rd = 32'h0;
        if (er) return;
        if (we) begin
            for (int k = 0; k < size; k++) begin
                case (rid)
                    0: m_mem[base[12:0] + 13'(off + k)] = wd[8*k +: 8];
                    1: m_ledr[8*(off+k) +: 8] = wd[8*k +: 8];
                    2: m_ledg[8*(off+k) +: 8] = wd[8*k +: 8];
                    default: m_hex[8*(off+k) +: 8] = wd[8*k +: 8];
                endcase
            end
        end else begin
            case (rid)
                0: for (int k = 0; k < 4; k++) w[8*k +: 8] = m_mem[base[12:0] + 13'(k)];
                1: w = m_ledr;
                2: w = m_ledg;
                3: w = m_hex;
                default: w = io_sw;
            endcase
            v = w >> (8 * off);
            if (size == 1)      rd = sgn ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
            else if (size == 2) rd = sgn ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
            else                rd = v;
        end
    endtask

    // Compare process: every cycle, all outputs against the model's expectations.
    always @(negedge clk) begin
        logic exp_ready, exp_valid;
        logic [31:0] exp_rdata;
        logic exp_err;
        exp_ready = 1'b1;
        exp_valid = 1'b0;
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        if (q.size() > 0 && (cyc == q[0].due - 1 || cyc == q[0].due)) exp_ready = 1'b0;
        if (q.size() > 0 && cyc == q[0].due) begin
            exp_valid = 1'b1;
            exp_rdata = q[0].rdata;
            exp_err   = q[0].err;
            cur_ledr  = q[0].ledr;
            cur_ledg  = q[0].ledg;
            cur_hex   = q[0].hex;
            void'(q.pop_front());
        end
        chk("req_ready", {31'h0, req_ready}, {31'h0, exp_ready});
        chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_valid});
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
        chk("io_ledr", io_ledr, cur_ledr);
        chk("io_ledg", io_ledg, cur_ledg);
        chk("io_hex", io_hex, cur_hex);
    end

    task automatic junk();
        req_valid  = 1'($urandom);
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    // Issue one request; returns the model's prediction. Leaves the DUT idle again.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit abort_in_access,
                        output logic [31:0] rd, output logic er);
        exp_t e;
        int waited = 0;
        rd = 32'h0;
        er = 1'b0;
        while (!req_ready && waited < 10) begin
            @(posedge clk); #2;
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got req_ready 0 expected 1 within 10 cycles");
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        model(we, f3, a, wd, rd, er);
        e.due   = cyc + 2;
        e.rdata = rd;
        e.err   = er;
        e.ledr  = m_ledr;
        e.ledg  = m_ledg;
        e.hex   = m_hex;
        q.push_back(e);
        @(posedge clk); #2;
        if (abort_in_access) begin
            rst = 1'b1;
            q.delete();
            m_ledr = 0; m_ledg = 0; m_hex = 0;
            cur_ledr = 0; cur_ledg = 0; cur_hex = 0;
            req_valid = 1'b0;
            @(posedge clk); #2;
            rst = 1'b0;
            return;
        end
        junk();
        @(posedge clk); #2;
        junk();
        @(posedge clk); #2;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
        end
    endtask

    logic [31:0] r;
    logic        e;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        io_sw = 32'h0;
        idle(3);
        rst = 1'b0;
        idle(2);

        send(1, 3'd2, 32'h100, 32'hDEADBEEF, 0, r, e);
        send(0, 3'd2, 32'h100, 0, 0, r, e);
        chk("pin_lw100", r, 32'hDEADBEEF);
        send(1, 3'd0, 32'h101, 32'h80, 0, r, e);
        send(0, 3'd0, 32'h101, 0, 0, r, e);
        chk("pin_lb101", r, 32'hFFFFFF80);
        send(0, 3'd4, 32'h101, 0, 0, r, e);
        chk("pin_lbu101", r, 32'h00000080);
        send(0, 3'd2, 32'h100, 0, 0, r, e);
        chk("pin_lw100b", r, 32'hDEAD80EF);
        send(0, 3'd1, 32'h102, 0, 0, r, e);
        chk("pin_lh102", r, 32'hFFFFDEAD);
        send(0, 3'd1, 32'h103, 0, 0, r, e);
        chk("pin_lh103_err", {31'h0, e}, 32'h1);
        send(1, 3'd2, 32'h102, 0, 0, r, e);
        chk("pin_sw102_err", {31'h0, e}, 32'h1);
        send(0, 3'd2, 32'h100, 0, 1'b0, r, e);
        chk("pin_lw100c", r, 32'hDEAD80EF);
        send(0, 3'd3, 32'h100, 0, 0, r, e);
        chk("pin_f3_011_err", {31'h0, e}, 32'h1);
        send(1, 3'd2, 32'h7000, 32'h12345678, 0, r, e);
        chk("pin_ledr", m_ledr, 32'h12345678);
        send(1, 3'd0, 32'h7021, 32'hAB, 0, r, e);
        chk("pin_hex", m_hex, 32'h0000AB00);
        send(1, 3'd2, 32'h7800, 32'h1, 0, r, e);
        chk("pin_sw_ro_err", {31'h0, e}, 32'h1);
        io_sw = 32'h5A5A0001;
        idle(3);
        send(0, 3'd2, 32'h7800, 0, 0, r, e);
        chk("pin_lw_sw", r, 32'h5A5A0001);
        send(0, 3'd2, 32'h2000, 0, 0, r, e);
        chk("pin_unmapped_err", {31'h0, e}, 32'h1);
        send(0, 3'd5, 32'h7802, 0, 0, r, e);
        chk("pin_lhu_sw", r, 32'h00005A5A);

        for (int i = 1; i < 16; i++) send(1, 3'd2, 32'h100 + 32'(4 * i), $urandom, 0, r, e);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            int pick;
            if ($urandom_range(7) == 0) begin
                io_sw = $urandom;
                idle(3);
            end
            pick = $urandom_range(9);
            case (pick)
                0, 1, 2, 3: a = 32'h100 + 32'($urandom_range(63));
                4: a = 32'h7000 + 32'($urandom_range(3));
                5: a = 32'h7010 + 32'($urandom_range(3));
                6: a = 32'h7020 + 32'($urandom_range(3));
                7: a = 32'h7800 + 32'($urandom_range(3));
                8: a = 32'h2000 + 32'($urandom_range(15));
                default: a = $urandom;
            endcase
            send(1'($urandom), 3'($urandom), a, $urandom, 0, r, e);
            if ($urandom_range(3) == 0) idle($urandom_range(3));
        end

        send(1, 3'd2, 32'h7010, 32'hFF, 0, r, e);
        send(1, 3'd2, 32'h7000, 32'hFF, 0, r, e);
        send(1, 3'd2, 32'h7010, 32'hFF, 1, r, e);
        send(0, 3'd2, 32'h7010, 0, 0, r, e);
        chk("pin_ledg_after_rst", r, 32'h0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
